// File: rtl/signal_narrow_pkg.sv
// Shared datapath constants for the word-to-halfword narrowing path.
// The fit check, the output buffer and the overflow counter all use them.
package signal_narrow_pkg;

    localparam int IN_W_DEF  = 32;
    localparam int OUT_W_DEF = 16;
    localparam int CNT_W_DEF = 16;
    localparam int BUF_DEPTH = 2;

    localparam logic [15:0] SAT_MAX = 16'h7FFF;
    localparam logic [15:0] SAT_MIN = 16'h8000;

    // Encoding is {push, pop} so the operation can be built directly from the two strobes.
    typedef enum logic [1:0] {
        BUF_IDLE = 2'b00,
        BUF_POP  = 2'b01,
        BUF_PUSH = 2'b10,
        BUF_BOTH = 2'b11
    } buf_op_e;

endpackage

// File: rtl/signal_narrow_fit.sv
// Combinational signed-range check and narrowing of one word.
// Kept standalone so assembler/immediate-check logic can reuse it.
import signal_narrow_pkg::*;

module signal_narrow_fit #(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic [IN_W-1:0]  word,
    input  logic             saturate,
    output logic [OUT_W-1:0] halfword,
    output logic             ovf
);

    logic [IN_W-OUT_W:0] upper_bits;
    logic                fits;

    // A word fits when every bit from the halfword sign bit upward is a copy of the sign.
    assign upper_bits = word[IN_W-1:OUT_W-1];
    assign fits       = (&upper_bits) | ~(|upper_bits);

    always_comb begin
        ovf      = ~fits;
        halfword = word[OUT_W-1:0];
        if (!fits && saturate) begin
            halfword = word[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                    : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/signal_narrow.sv
// Stream narrower: 32-bit signed words in, 16-bit signed halfwords out,
// through a 2-entry buffer with a saturating count of out-of-range words.
import signal_narrow_pkg::*;

module signal_narrow #(
    parameter int IN_W     = IN_W_DEF,
    parameter int OUT_W    = OUT_W_DEF,
    parameter bit SATURATE = 1'b1,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             clr_count
);

    logic [OUT_W-1:0] fit_data;
    logic             fit_ovf;

    logic [OUT_W-1:0] data_q [BUF_DEPTH];
    logic [OUT_W-1:0] data_d [BUF_DEPTH];
    logic             ovf_q  [BUF_DEPTH];
    logic             ovf_d  [BUF_DEPTH];
    logic [1:0]       occupancy_q;
    logic [1:0]       occupancy_d;
    logic [CNT_W-1:0] ovf_count_q;
    logic [CNT_W-1:0] ovf_count_d;

    logic             push;
    logic             pop;
    buf_op_e          buf_op;

    signal_narrow_fit #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_fit (
        .word     (in_data),
        .saturate (SATURATE),
        .halfword (fit_data),
        .ovf      (fit_ovf)
    );

    // in_ready depends only on registered occupancy so no combinational path runs from out_ready.
    assign in_ready  = (occupancy_q < 2'd2);
    assign out_valid = (occupancy_q != 2'd0);
    assign out_data  = data_q[0];
    assign out_ovf   = ovf_q[0];
    assign ovf_count = ovf_count_q;

    // Entry 0 is always the head; a pop shifts entry 1 forward.
    always_comb begin
        push        = in_valid && in_ready;
        pop         = out_valid && out_ready;
        buf_op      = buf_op_e'({push, pop});
        data_d      = data_q;
        ovf_d       = ovf_q;
        occupancy_d = occupancy_q;
        case (buf_op)
            BUF_PUSH: begin
                if (occupancy_q == 2'd0) begin
                    data_d[0] = fit_data;
                    ovf_d[0]  = fit_ovf;
                end else begin
                    data_d[1] = fit_data;
                    ovf_d[1]  = fit_ovf;
                end
                occupancy_d = occupancy_q + 2'd1;
            end
            BUF_POP: begin
                data_d[0]   = data_q[1];
                ovf_d[0]    = ovf_q[1];
                occupancy_d = occupancy_q - 2'd1;
            end
            BUF_BOTH: begin
                // Only reachable with one entry held, so the new word becomes the head.
                data_d[0] = fit_data;
                ovf_d[0]  = fit_ovf;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        ovf_count_d = ovf_count_q;
        if (clr_count) begin
            ovf_count_d = (push && fit_ovf) ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
        end else if (push && fit_ovf && !(&ovf_count_q)) begin
            ovf_count_d = ovf_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                data_q[i] <= '0;
                ovf_q[i]  <= 1'b0;
            end
            occupancy_q <= 2'd0;
            ovf_count_q <= '0;
        end else begin
            data_q      <= data_d;
            ovf_q       <= ovf_d;
            occupancy_q <= occupancy_d;
            ovf_count_q <= ovf_count_d;
        end
    end

endmodule

// File: tb/tb_signal_narrow.sv
// Bench for signal_narrow: a saturating instance and a truncating, narrow-counter
// instance share one stimulus stream and are checked against a queue-based model.
module tb_signal_narrow;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        clr_count;

    logic        a_in_ready, a_out_valid, a_out_ovf;
    logic [15:0] a_out_data;
    logic [15:0] a_ovf_count;
    logic        b_in_ready, b_out_valid, b_out_ovf;
    logic [15:0] b_out_data;
    logic [3:0]  b_ovf_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [16:0] qa[$];
    logic [16:0] qb[$];
    int          cnt_a;
    int          cnt_b;

    always #5 clk = ~clk;

    signal_narrow #(.IN_W(32), .OUT_W(16), .SATURATE(1'b1), .CNT_W(16)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (a_in_ready),
        .in_data   (in_data),
        .out_valid (a_out_valid),
        .out_ready (out_ready),
        .out_data  (a_out_data),
        .out_ovf   (a_out_ovf),
        .ovf_count (a_ovf_count),
        .clr_count (clr_count)
    );

    signal_narrow #(.IN_W(32), .OUT_W(16), .SATURATE(1'b0), .CNT_W(4)) dut_trunc (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (b_in_ready),
        .in_data   (in_data),
        .out_valid (b_out_valid),
        .out_ready (out_ready),
        .out_data  (b_out_data),
        .out_ovf   (b_out_ovf),
        .ovf_count (b_ovf_count),
        .clr_count (clr_count)
    );

    // Reference narrowing from signed value range, returns {ovf, halfword}.
    function automatic logic [16:0] narrow_ref(input logic [31:0] w, input bit sat);
        int signed   v;
        logic [15:0] r;
        bit          o;
        v = $signed(w);
        o = (v > 32767) || (v < -32768);
        r = w[15:0];
        if (o && sat) r = (v > 0) ? 16'h7FFF : 16'h8000;
        return {o, r};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    endtask

    task automatic applyStimulus(input logic [31:0] d, input bit v, input bit r, input bit c);
        in_data   = d;
        in_valid  = v;
        out_ready = r;
        clr_count = c;
        @(posedge clk);
        #1;
    endtask

    // Model: compare at the falling edge, then advance it by the upcoming rising edge.
    always @(negedge clk) begin
        bit          acc;
        logic [16:0] ea;
        logic [16:0] eb;
        logic [16:0] head;
        if (rst) begin
            qa.delete();
            qb.delete();
            cnt_a = 0;
            cnt_b = 0;
        end
        checkOutput("m_in_ready_a", {31'b0, a_in_ready}, {31'b0, qa.size() < 2});
        checkOutput("m_in_ready_b", {31'b0, b_in_ready}, {31'b0, qb.size() < 2});
        checkOutput("m_out_valid_a", {31'b0, a_out_valid}, {31'b0, qa.size() > 0});
        checkOutput("m_out_valid_b", {31'b0, b_out_valid}, {31'b0, qb.size() > 0});
        if (qa.size() > 0) begin
            head = qa[0];
            checkOutput("m_out_data_a", {16'b0, a_out_data}, {16'b0, head[15:0]});
            checkOutput("m_out_ovf_a", {31'b0, a_out_ovf}, {31'b0, head[16]});
        end
        if (qb.size() > 0) begin
            head = qb[0];
            checkOutput("m_out_data_b", {16'b0, b_out_data}, {16'b0, head[15:0]});
            checkOutput("m_out_ovf_b", {31'b0, b_out_ovf}, {31'b0, head[16]});
        end
        checkOutput("m_ovf_count_a", {16'b0, a_ovf_count}, cnt_a);
        checkOutput("m_ovf_count_b", {28'b0, b_ovf_count}, cnt_b);
        if (!rst) begin
            acc = in_valid && (qa.size() < 2);
            ea  = narrow_ref(in_data, 1'b1);
            eb  = narrow_ref(in_data, 1'b0);
            if (out_ready && qa.size() > 0) void'(qa.pop_front());
            if (out_ready && qb.size() > 0) void'(qb.pop_front());
            if (acc) begin
                qa.push_back(ea);
                qb.push_back(eb);
            end
            if (clr_count) begin
                cnt_a = (acc && ea[16]) ? 1 : 0;
                cnt_b = (acc && eb[16]) ? 1 : 0;
            end else begin
                if (acc && ea[16] && cnt_a < 65535) cnt_a++;
                if (acc && eb[16] && cnt_b < 15) cnt_b++;
            end
        end
    end

    logic [31:0] inr_words [4] = '{32'h00005555, 32'hFFFFAAAA, 32'h00007FFF, 32'hFFFF8000};
    logic [15:0] inr_exp   [4] = '{16'h5555, 16'hAAAA, 16'h7FFF, 16'h8000};
    logic [31:0] ovf_words [3] = '{32'h00008000, 32'hFFFF7FFF, 32'h12345678};
    logic [15:0] ovf_sat   [3] = '{16'h7FFF, 16'h8000, 16'h7FFF};
    logic [15:0] ovf_trunc [3] = '{16'h8000, 16'h7FFF, 16'h5678};
    logic [31:0] edge_words [8] = '{32'h00007FFF, 32'h00008000, 32'hFFFF8000, 32'hFFFF7FFF,
                                    32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'hFFFFFFFF};

    initial begin
        logic [31:0] d;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        clr_count = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        checkOutput("pin_sat_pos", {15'b0, narrow_ref(32'h00008000, 1'b1)}, {15'b0, 17'h17FFF});
        checkOutput("pin_sat_neg", {15'b0, narrow_ref(32'hFFFF7FFF, 1'b1)}, {15'b0, 17'h18000});
        checkOutput("pin_trunc", {15'b0, narrow_ref(32'h12345678, 1'b0)}, {15'b0, 17'h15678});
        checkOutput("pin_fit_max", {15'b0, narrow_ref(32'h00007FFF, 1'b1)}, {15'b0, 17'h07FFF});
        checkOutput("pin_fit_min", {15'b0, narrow_ref(32'hFFFF8000, 1'b1)}, {15'b0, 17'h08000});

        checkOutput("rst_out_valid", {31'b0, a_out_valid}, 32'd0);
        checkOutput("rst_in_ready", {31'b0, a_in_ready}, 32'd1);
        checkOutput("rst_ovf_count", {16'b0, a_ovf_count}, 32'd0);
        checkOutput("rst_out_data", {16'b0, a_out_data}, 32'd0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(inr_words[i], 1'b1, 1'b1, 1'b0);
            checkOutput("inrange_valid", {31'b0, a_out_valid}, 32'd1);
            checkOutput("inrange_data", {16'b0, a_out_data}, {16'b0, inr_exp[i]});
            checkOutput("inrange_ovf", {31'b0, a_out_ovf}, 32'd0);
        end
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("inrange_drained", {31'b0, a_out_valid}, 32'd0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(ovf_words[i], 1'b1, 1'b1, 1'b0);
            checkOutput("ovf_sat_data", {16'b0, a_out_data}, {16'b0, ovf_sat[i]});
            checkOutput("ovf_trunc_data", {16'b0, b_out_data}, {16'b0, ovf_trunc[i]});
            checkOutput("ovf_flag", {30'b0, a_out_ovf, b_out_ovf}, 32'd3);
        end
        checkOutput("ovf_count_sat", {16'b0, a_ovf_count}, 32'd3);
        checkOutput("ovf_count_trunc", {28'b0, b_ovf_count}, 32'd3);
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);

        applyStimulus(32'h00001111, 1'b1, 1'b0, 1'b0);
        checkOutput("bp_ready_1", {31'b0, a_in_ready}, 32'd1);
        checkOutput("bp_data_1", {16'b0, a_out_data}, 32'h1111);
        applyStimulus(32'h00012345, 1'b1, 1'b0, 1'b0);
        checkOutput("bp_ready_full", {31'b0, a_in_ready}, 32'd0);
        checkOutput("bp_data_2", {16'b0, a_out_data}, 32'h1111);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(32'hFFFFFFFE, 1'b1, 1'b0, 1'b0);
            checkOutput("bp_hold_ready", {31'b0, a_in_ready}, 32'd0);
            checkOutput("bp_hold_data", {16'b0, a_out_data}, 32'h1111);
            checkOutput("bp_hold_ovf", {31'b0, a_out_ovf}, 32'd0);
        end
        applyStimulus(32'hFFFFFFFE, 1'b1, 1'b1, 1'b0);
        checkOutput("bp_second_sat", {16'b0, a_out_data}, 32'h7FFF);
        checkOutput("bp_second_trunc", {16'b0, b_out_data}, 32'h2345);
        checkOutput("bp_second_ovf", {31'b0, a_out_ovf}, 32'd1);
        checkOutput("bp_ready_again", {31'b0, a_in_ready}, 32'd1);
        applyStimulus(32'hFFFFFFFE, 1'b1, 1'b1, 1'b0);
        checkOutput("bp_third", {16'b0, a_out_data}, 32'hFFFE);
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("bp_no_dup", {31'b0, a_out_valid}, 32'd0);
        checkOutput("bp_count", {16'b0, a_ovf_count}, 32'd4);

        // The 4-bit counter instance reaches its all-ones limit after 11 more overflows.
        for (int i = 0; i < 13; i++) applyStimulus(32'h40000000, 1'b1, 1'b1, 1'b0);
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("cnt_saturated", {28'b0, b_ovf_count}, 32'hF);
        checkOutput("cnt_wide", {16'b0, a_ovf_count}, 32'd17);
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b1);
        checkOutput("cnt_clr_a", {16'b0, a_ovf_count}, 32'd0);
        checkOutput("cnt_clr_b", {28'b0, b_ovf_count}, 32'd0);
        applyStimulus(32'h80000000, 1'b1, 1'b1, 1'b1);
        checkOutput("cnt_clr_ovf_a", {16'b0, a_ovf_count}, 32'd1);
        checkOutput("cnt_clr_ovf_b", {28'b0, b_ovf_count}, 32'd1);
        checkOutput("cnt_clr_data_a", {16'b0, a_out_data}, 32'h8000);
        checkOutput("cnt_clr_data_b", {16'b0, b_out_data}, 32'h0000);
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);

        applyStimulus(32'h00000001, 1'b1, 1'b0, 1'b0);
        applyStimulus(32'h00000002, 1'b1, 1'b0, 1'b0);
        checkOutput("prerst_full", {31'b0, a_in_ready}, 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_valid", {31'b0, a_out_valid}, 32'd0);
        checkOutput("async_rst_count", {16'b0, a_ovf_count}, 32'd0);
        checkOutput("async_rst_ready", {31'b0, a_in_ready}, 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
            checkOutput("postrst_silent", {31'b0, a_out_valid}, 32'd0);
        end

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       d = $urandom();
                1:       d = 32'($urandom_range(0, 32767));
                2:       d = 32'hFFFF8000 | 32'($urandom_range(0, 32767));
                default: d = edge_words[$urandom_range(0, 7)];
            endcase
            applyStimulus(d, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 31) == 0);
        end
        for (int i = 0; i < 3; i++) applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/signal_narrow.md
Name: signal_narrow

Overview:
Inverse of the immediate sign extender: converts a stream of 32-bit signed words into 16-bit signed halfwords for store-halfword and immediate-encoding paths. Each word is checked for signed 16-bit range and saturated or truncated if it does not fit; out-of-range words are flagged and counted. A valid/ready handshake on both sides and a 2-entry output buffer give full throughput with one cycle of latency.

Parameters:
IN_W, 32, input word width
OUT_W, 16, output halfword width (OUT_W < IN_W)
SATURATE, 1, 1 = clamp out-of-range words to the signed limits; 0 = truncate to the low OUT_W bits
CNT_W, 16, width of the overflow counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a word
in_data  input  IN_W  signed word to narrow
out_valid  output  1  out_data/out_ovf are valid
out_ready  input  1  downstream accepts the output
out_data  output  OUT_W  narrowed signed halfword
out_ovf  output  1  word did not fit in OUT_W signed bits
ovf_count  output  CNT_W  number of accepted words that overflowed
clr_count  input  1  synchronous clear of ovf_count

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset value of every output and state element is 0, including the buffer occupancy, out_valid, out_data, out_ovf and ovf_count. in_ready is 1 after reset is released because the buffer is empty.
- Asserting rst during operation discards all buffered words. No partial output is produced after reset.
- Fit check: a word fits when in_data[IN_W-1:OUT_W-1] (17 bits at the defaults) is all 0s or all 1s.
- If the word fits, the result is in_data[OUT_W-1:0] and ovf is 0.
- If the word does not fit:
  - ovf is 1.
  - With SATURATE=1, the result is 16'h7FFF when in_data[IN_W-1]=0 and 16'h8000 when in_data[IN_W-1]=1.
  - With SATURATE=0, the result is in_data[OUT_W-1:0].
- Accept: a word is accepted when in_valid && in_ready. The narrowed result and its ovf bit are written to the buffer tail on the same edge.
- Buffer: 2 entries. in_ready = (occupancy < 2), driven combinationally from registered occupancy only, never from out_ready.
- Output: out_valid = (occupancy > 0). out_data/out_ovf show the head entry. The head is popped when out_valid && out_ready.
- Latency: a word accepted at edge N is visible on the outputs after edge N if the buffer was empty. Throughput is 1 word per cycle while out_ready stays high.
- Push and pop on the same edge leave occupancy unchanged; the pushed entry goes behind the remaining entry.
- When full, in_ready=0 and no push can occur, even if a pop happens on that edge.
- Ordering is strict FIFO. Output values stay stable while out_valid && !out_ready.
- ovf_count increments on each accepted word with ovf=1 and saturates at all-ones (no wrap).
- clr_count has priority: the counter goes to 0. If an overflowing word is accepted on the same edge, the counter goes to 1.
- in_data is ignored when in_valid=0.

Decomposition:
- Shared package (alongside the existing datapath constants): IN_W/OUT_W defaults, SAT_MAX=16'h7FFF, SAT_MIN=16'h8000.
- One combinational sub-module, signal_narrow_fit: inputs word and SATURATE; outputs halfword and ovf. It is reusable by the assembler/immediate-check logic.
- The 2-entry buffer, handshake and counter live in the top module.

Test Plan:
- Reset: assert rst mid-stream with 2 entries buffered -> out_valid=0, ovf_count=0, in_ready=1 immediately (asynchronous); nothing emitted afterwards.
- In-range words with out_ready=1, inputs 32'h00005555, 32'hFFFFAAAA, 32'h00007FFF, 32'hFFFF8000 -> outputs 16'h5555, 16'hAAAA, 16'h7FFF, 16'h8000, out_ovf=0, one per cycle, each 1 cycle after acceptance.
- Overflow, SATURATE=1, inputs 32'h00008000, 32'hFFFF7FFF, 32'h12345678 -> 16'h7FFF, 16'h8000, 16'h7FFF, out_ovf=1 each, ovf_count=3. Same inputs with SATURATE=0 -> 16'h8000, 16'h7FFF, 16'h5678.
- Backpressure: hold out_ready=0 while feeding 3 words -> in_ready drops after 2 accepts and out_data stays stable. Release out_ready -> the 3 words emerge in order with no loss or duplication.
- Counter edges: preload ovf_count to 16'hFFFF with an overflow word -> stays 16'hFFFF. Assert clr_count alone -> 0. Assert clr_count together with an accepted overflow word -> 1.
- Random stream with random in_valid/out_ready against a reference model -> exact match of out_data, out_ovf and ovf_count.
